// File: rtl/pin_lockout_ctrl.sv
// Wrong-PIN lockout sequencer: counts failed PIN entries, holds the lock timer running
// during lockout, and gates access_grant for the transaction FSM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no card; outputs idle
// S_ENTRY   | card present, waiting for PIN submissions
// S_GRANTED | correct PIN accepted; session open until card removed
// S_LOCKED  | tries exhausted; timer running, keypad disabled
// S_RELEASE | timer expired; waiting for time_up to clear before unlocking
module pin_lockout_ctrl #(
   parameter int MAX_ATTEMPTS = 3,
   parameter int AW           = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          card_in_i,
   input  logic          pin_valid_i,
   input  logic          pin_ok_i,
   input  logic          time_up_i,
   output logic          start_timer_o,
   output logic          locked_o,
   output logic          access_grant_o,
   output logic          pin_fail_o,
   output logic [AW-1:0] attempts_left_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_GRANTED = 3'd2,
      S_LOCKED  = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [AW-1:0] MAX_L = AW'(MAX_ATTEMPTS);
   localparam logic [AW-1:0] ONE_L = AW'(1);

   state_t        state_q, state_d;
   logic          start_q, start_d;
   logic          locked_q, locked_d;
   logic          grant_q, grant_d;
   logic          fail_q, fail_d;
   logic [AW-1:0] attempts_q, attempts_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         locked_q   <= 1'b0;
         grant_q    <= 1'b0;
         fail_q     <= 1'b0;
         attempts_q <= MAX_L;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         locked_q   <= locked_d;
         grant_q    <= grant_d;
         fail_q     <= fail_d;
         attempts_q <= attempts_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      locked_d   = locked_q;
      grant_d    = grant_q;
      fail_d     = 1'b0;
      attempts_d = attempts_q;
      case (state_q)
         S_IDLE: begin
            start_d  = 1'b0;
            locked_d = 1'b0;
            grant_d  = 1'b0;
            if (card_in_i) state_d = S_ENTRY;
         end
         S_ENTRY: begin
            // Card removal wins over a same-cycle PIN strobe; the count is kept.
            if (!card_in_i) begin
               state_d = S_IDLE;
            end else if (pin_valid_i) begin
               if (pin_ok_i) begin
                  state_d    = S_GRANTED;
                  grant_d    = 1'b1;
                  attempts_d = MAX_L;
               end else if (attempts_q > ONE_L) begin
                  fail_d     = 1'b1;
                  attempts_d = attempts_q - ONE_L;
               end else begin
                  state_d    = S_LOCKED;
                  fail_d     = 1'b1;
                  attempts_d = '0;
                  start_d    = 1'b1;
                  locked_d   = 1'b1;
               end
            end
         end
         S_GRANTED: begin
            grant_d = 1'b1;
            if (!card_in_i) begin
               state_d = S_IDLE;
               grant_d = 1'b0;
            end
         end
         S_LOCKED: begin
            start_d  = 1'b1;
            locked_d = 1'b1;
            if (time_up_i) begin
               state_d    = S_RELEASE;
               start_d    = 1'b0;
               attempts_d = MAX_L;
            end
         end
         S_RELEASE: begin
            // The timer holds time_up one cycle past start_timer falling.
            start_d  = 1'b0;
            locked_d = 1'b1;
            if (!time_up_i) begin
               state_d  = S_IDLE;
               locked_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            start_d  = 1'b0;
            locked_d = 1'b0;
            grant_d  = 1'b0;
         end
      endcase
   end

   assign start_timer_o   = start_q;
   assign locked_o        = locked_q;
   assign access_grant_o  = grant_q;
   assign pin_fail_o      = fail_q;
   assign attempts_left_o = attempts_q;

endmodule

// File: tb/tb_pin_lockout_ctrl.sv
// Directed bench for pin_lockout_ctrl with MAX_ATTEMPTS=3, AW=2.
module tb_pin_lockout_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       card_in;
   logic       pin_valid;
   logic       pin_ok;
   logic       time_up;
   logic       start_timer;
   logic       locked;
   logic       access_grant;
   logic       pin_fail;
   logic [1:0] attempts_left;

   int n_checks = 0;
   int n_fail   = 0;

   pin_lockout_ctrl #(.MAX_ATTEMPTS(3), .AW(2)) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .card_in_i       (card_in),
      .pin_valid_i     (pin_valid),
      .pin_ok_i        (pin_ok),
      .time_up_i       (time_up),
      .start_timer_o   (start_timer),
      .locked_o        (locked),
      .access_grant_o  (access_grant),
      .pin_fail_o      (pin_fail),
      .attempts_left_o (attempts_left)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic st, input logic lk,
                          input logic gr, input logic pf, input logic [1:0] al);
      chk1({tag, ".start_timer"},  start_timer,   st);
      chk1({tag, ".locked"},       locked,        lk);
      chk1({tag, ".access_grant"}, access_grant,  gr);
      chk1({tag, ".pin_fail"},     pin_fail,      pf);
      chkn({tag, ".attempts_left"}, attempts_left, al);
   endtask

   initial begin
      rst_n = 1'b0; card_in = 1'b0; pin_valid = 1'b0; pin_ok = 1'b0; time_up = 1'b0;
      #12;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      rst_n = 1'b1;

      // Correct PIN on first try, then card removal
      card_in = 1'b1;
      tick();
      chk_all("entry", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      pin_valid = 1'b1; pin_ok = 1'b1;
      tick();
      chk_all("grant", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
      pin_valid = 1'b1; pin_ok = 1'b0;
      tick();
      chk_all("grant_ignore_pin", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
      pin_valid = 1'b0; card_in = 1'b0;
      tick();
      chk_all("grant_card_out", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

      // Two wrong PINs, count survives card removal, correct PIN reloads
      card_in = 1'b1;
      tick();
      pin_valid = 1'b1; pin_ok = 1'b0;
      tick();
      chk_all("wrong1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      pin_valid = 1'b0;
      tick();
      chk_all("wrong1_pulse_end", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      pin_valid = 1'b1;
      tick();
      chk_all("wrong2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      pin_valid = 1'b0; card_in = 1'b0;
      tick();
      chk_all("removed_keeps_count", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      card_in = 1'b1;
      tick();
      chk_all("reinsert_keeps_count", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      pin_valid = 1'b1; pin_ok = 1'b1;
      tick();
      chk_all("correct_reload", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
      pin_valid = 1'b0; card_in = 1'b0;
      tick();

      // Card removed in the same cycle as a wrong PIN, after one failure
      card_in = 1'b1;
      tick();
      pin_valid = 1'b1; pin_ok = 1'b0;
      tick();
      chk_all("prep_wrong", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      card_in = 1'b0;
      tick();
      chk_all("card_out_drops_pin", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      tick();
      chk_all("idle_ignores_pin", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      pin_valid = 1'b0; time_up = 1'b1;
      tick();
      chk_all("idle_ignores_time_up", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      time_up = 1'b0;

      // Lockout from 2 remaining tries
      card_in = 1'b1;
      tick();
      pin_valid = 1'b1; pin_ok = 1'b0;
      tick();
      chk_all("lk_wrong_a", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      tick();
      chk_all("lk_lock", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
      tick();
      chk_all("lk_no_more_fail", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      pin_valid = 1'b0; card_in = 1'b0;
      tick();
      chk_all("lk_card_out", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk1("lk_hold.start_timer", start_timer, 1'b1);
      end
      time_up = 1'b1;
      tick();
      chk_all("release_1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
      tick();
      chk_all("release_2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
      time_up = 1'b0;
      tick();
      chk_all("unlocked", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

      // Full three-strike lockout, then asynchronous reset mid-lock
      card_in = 1'b1;
      tick();
      pin_valid = 1'b1; pin_ok = 1'b0;
      tick();
      chk_all("s3_wrong1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      tick();
      chk_all("s3_wrong2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      tick();
      chk_all("s3_lock", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
      pin_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      #4;
      rst_n = 1'b1;
      tick();
      chk_all("after_reset_entry", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
